// File: rtl/me_seq_pkg.sv
// rtl/me_seq_pkg.sv - LilME opcodes and job sequencer state encoding
package me_seq_pkg;

  localparam logic [2:0] OP_IDLE   = 3'b000;
  localparam logic [2:0] OP_LDADDR = 3'b001;
  localparam logic [2:0] OP_LDA    = 3'b010;
  localparam logic [2:0] OP_LDB    = 3'b011;
  localparam logic [2:0] OP_MUL    = 3'b101;
  localparam logic [2:0] OP_READ   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD_A,
    S_LOAD_B,
    S_MUL,
    S_WAIT,
    S_READ
  } seq_state_e;

endpackage

// File: rtl/me_seq_outbuf.sv
// rtl/me_seq_outbuf.sv - 2-entry result FIFO carrying {last, data}
module me_seq_outbuf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tvalid,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    push  = s_tvalid && (cnt_q != 2'd2);
    pop   = (cnt_q != 2'd0) && m_tready;
    if (push) begin
      mem_d[wr_q] = s_tdata;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign m_tvalid = (cnt_q != 2'd0);
  assign m_tdata  = mem_q[rd_q];
  assign count    = cnt_q;

endmodule

// File: rtl/me_job_sequencer.sv
// rtl/me_job_sequencer.sv - runs one LilME matrix-multiply job from a host stream
// Define ME_SEQ_TIMEOUT_EN to bound WAIT by TMO cycles and add the timeout_err port.
module me_job_sequencer
  import me_seq_pkg::*;
#(
  parameter int dw     = 31,
  parameter int aw     = 31,
  parameter int row    = 4,
  parameter int col    = 4,
  parameter int RD_LAT = 1
`ifdef ME_SEQ_TIMEOUT_EN
  , parameter int TMO  = 1024
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [aw:0]   cmd_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [dw:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [dw:0]   out_data,
  output logic          out_last,
  output logic          done,
  output logic [2:0]    ME_opcode,
  output logic          A_opcode,
  output logic          B_opcode,
  output logic [aw:0]   Address_out,
  output logic [dw:0]   Data_in,
  input  logic          Busy,
  input  logic [dw:0]   result
`ifdef ME_SEQ_TIMEOUT_EN
  , output logic        timeout_err
`endif
);

  localparam int N  = row * col;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  seq_state_e    state_q, state_d;
  logic [aw:0]   addr_q, addr_d, addr_out_q, addr_out_d;
  logic [dw:0]   data_in_q, data_in_d;
  logic [CW-1:0] cnt_q, cnt_d, cap_q, cap_d;
  logic [1:0]    infl_q, infl_d, fifo_cnt;
  logic [RD_LAT:0] rd_pipe_q, rd_pipe_d;
  logic [2:0]    me_op_q, me_op_d;
  logic          a_op_q, a_op_d, b_op_q, b_op_d, cmd_rdy_q, cmd_rdy_d;
  logic          issue, capture, head_last;
  logic [dw+1:0] head;
`ifdef ME_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_err_q, tmo_err_d;
`endif

  // rd_pipe bit RD_LAT marks the cycle the engine result for a READ is valid
  assign capture = rd_pipe_q[RD_LAT];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    me_op_d    = OP_IDLE;
    a_op_d     = 1'b0;
    b_op_d     = 1'b0;
    addr_out_d = addr_out_q;
    data_in_d  = data_in_q;
    issue      = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
`ifdef ME_SEQ_TIMEOUT_EN
    tmo_d      = tmo_q;
    tmo_err_d  = tmo_err_q;
`endif
    case (state_q)
      S_IDLE: if (cmd_rdy_q && cmd_valid) begin
        addr_d  = cmd_addr;
        cnt_d   = '0;
        state_d = S_ADDR;
`ifdef ME_SEQ_TIMEOUT_EN
        tmo_err_d = 1'b0;
`endif
      end
      S_ADDR: begin
        me_op_d    = OP_LDADDR;
        addr_out_d = addr_q;
        cnt_d      = '0;
        state_d    = S_LOAD_A;
      end
      S_LOAD_A, S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          me_op_d   = (state_q == S_LOAD_A) ? OP_LDA : OP_LDB;
          a_op_d    = (state_q == S_LOAD_A);
          b_op_d    = (state_q == S_LOAD_B);
          data_in_d = in_data;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_MUL;
          end
        end
      end
      S_MUL: begin
        me_op_d = OP_MUL;
        cnt_d   = '0;
        state_d = S_WAIT;
`ifdef ME_SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        // cnt_q==0 only in the first WAIT cycle, where Busy may still be low
        cnt_d = CW'(1);
`ifdef ME_SEQ_TIMEOUT_EN
        tmo_d = tmo_q + TW'(1);
`endif
        if (cnt_q != '0 && !Busy) begin
          cnt_d   = '0;
          cap_d   = '0;
          state_d = S_READ;
        end
`ifdef ME_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TMO - 1)) begin
          tmo_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
`endif
      end
      S_READ: begin
        if (cnt_q != CW'(N) && (({1'b0, fifo_cnt} + {1'b0, infl_q}) < 3'd2)) begin
          issue   = 1'b1;
          me_op_d = OP_READ;
          cnt_d   = cnt_q + CW'(1);
        end
        if (out_valid && out_ready && head_last) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) cap_d = cap_q + CW'(1);
    infl_d    = infl_q + {1'b0, issue} - {1'b0, capture};
    rd_pipe_d = {rd_pipe_q[RD_LAT-1:0], issue};
    cmd_rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      addr_out_q <= '0;
      data_in_q  <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      infl_q     <= '0;
      rd_pipe_q  <= '0;
      me_op_q    <= OP_IDLE;
      a_op_q     <= 1'b0;
      b_op_q     <= 1'b0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_out_q <= addr_out_d;
      data_in_q  <= data_in_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      infl_q     <= infl_d;
      rd_pipe_q  <= rd_pipe_d;
      me_op_q    <= me_op_d;
      a_op_q     <= a_op_d;
      b_op_q     <= b_op_d;
      cmd_rdy_q  <= cmd_rdy_d;
    end
  end

`ifdef ME_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end
  assign timeout_err = tmo_err_q;
`endif

  me_seq_outbuf #(.W(dw + 2)) u_outbuf (
    .clk      (clk),
    .rst_n    (reset),
    .s_tvalid (capture),
    .s_tdata  ({cap_q == LAST, result}),
    .m_tvalid (out_valid),
    .m_tready (out_ready),
    .m_tdata  (head),
    .count    (fifo_cnt)
  );

  assign head_last   = head[dw+1];
  assign out_data    = head[dw:0];
  assign out_last    = out_valid && head_last;
  assign cmd_ready   = cmd_rdy_q;
  assign ME_opcode   = me_op_q;
  assign A_opcode    = a_op_q;
  assign B_opcode    = b_op_q;
  assign Address_out = addr_out_q;
  assign Data_in     = data_in_q;

endmodule

// File: tb/tb_me_job_sequencer.sv
// tb/tb_me_job_sequencer.sv - scoreboard bench for me_job_sequencer
module tb_me_job_sequencer;
  import me_seq_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid, out_ready = 1'b1, out_last, done;
  logic [31:0] out_data;
  logic [2:0]  ME_opcode;
  logic        A_opcode, B_opcode;
  logic [31:0] Address_out, Data_in;
  logic        Busy = 1'b0;
  logic [31:0] result = '0;
`ifdef ME_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  me_job_sequencer #(
    .dw(31), .aw(31), .row(4), .col(4), .RD_LAT(1)
`ifdef ME_SEQ_TIMEOUT_EN
    , .TMO(32)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done),
    .ME_opcode(ME_opcode), .A_opcode(A_opcode), .B_opcode(B_opcode),
    .Address_out(Address_out), .Data_in(Data_in),
    .Busy(Busy), .result(result)
`ifdef ME_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  typedef struct packed {
    logic [2:0]  op;
    logic        a;
    logic        b;
    logic [31:0] val;
  } ev_t;

  ev_t         exp_ev[$];
  logic [32:0] exp_out[$];
  ev_t         mon_e;
  logic [32:0] mon_w;
  logic [31:0] held_data;
  bit          held_valid = 0;
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0;
  int first_lda = -1, last_lda = -1, first_rd_cyc = -1, fall_cyc = -1;
  int busy_len = 0, busy_n = 0;
  bit busy_stuck = 0;
  bit prev_rd = 0;
  int rd_idx = 0;
  logic [31:0] res_base = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine stub: the word for a READ seen in cycle t is driven during cycle t+1
  always @(negedge clk) begin
    result = prev_rd ? res_base + 32'(rd_idx) : 32'hDEADBEEF;
    if (prev_rd) rd_idx++;
    prev_rd = reset && (ME_opcode == OP_READ);
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset && ME_opcode == OP_MUL && (busy_len > 0 || busy_stuck)) begin
        Busy = 1'b1;
        busy_n = 0;
        while ((busy_stuck || busy_n < busy_len) && reset) begin
          @(negedge clk);
          busy_n++;
        end
        Busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  // Engine-bus monitor
  always @(negedge clk) begin
    if (reset) begin
      if (ME_opcode != OP_IDLE) begin
        if (exp_ev.size() == 0) chk("bus_unexpected", 64'(ME_opcode), 64'(OP_IDLE));
        else begin
          mon_e = exp_ev.pop_front();
          chk("bus_op", 64'({A_opcode, B_opcode, ME_opcode}), 64'({mon_e.a, mon_e.b, mon_e.op}));
          if (ME_opcode == OP_LDADDR) chk("bus_addr", 64'(Address_out), 64'(mon_e.val));
          if (ME_opcode == OP_LDA || ME_opcode == OP_LDB) chk("bus_data", 64'(Data_in), 64'(mon_e.val));
        end
        if (ME_opcode == OP_LDA) begin
          if (first_lda < 0) first_lda = cyc;
          last_lda = cyc;
        end
        if (ME_opcode == OP_READ && first_rd_cyc < 0) first_rd_cyc = cyc;
      end else if (A_opcode || B_opcode) begin
        chk("bus_strobe_idle", 64'({A_opcode, B_opcode}), 64'd0);
      end
    end
  end

  // Result-stream monitor
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("out_unexpected", 64'(out_valid), 64'd0);
        else begin
          mon_w = exp_out.pop_front();
          chk("out_word", 64'({out_last, out_data}), 64'(mon_w));
          chk("done_at_last", 64'(done), 64'(mon_w[32]));
        end
        if (done) done_cnt++;
      end else if (done) begin
        chk("done_spurious", 64'(done), 64'd0);
      end
      if (out_valid && !out_ready) begin
        if (held_valid && out_data !== held_data) chk("out_hold", 64'(out_data), 64'(held_data));
        held_data  = out_data;
        held_valid = 1;
      end else held_valid = 0;
    end else held_valid = 0;
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_me_op"}, 64'(ME_opcode), 64'd0);
    chk({tag, "_ab_op"}, 64'({A_opcode, B_opcode}), 64'd0);
    chk({tag, "_addr_out"}, 64'(Address_out), 64'd0);
    chk({tag, "_data_in"}, 64'(Data_in), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_flags"}, 64'({out_valid, out_last, done}), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  task automatic push_job(input logic [31:0] addr, input logic [31:0] abase, input logic [31:0] ainc,
                          input logic [31:0] bbase, input logic [31:0] binc,
                          input logic [31:0] rbase, input bit reads);
    exp_ev.push_back(ev_t'{op: OP_LDADDR, a: 1'b0, b: 1'b0, val: addr});
    for (int i = 0; i < N; i++) exp_ev.push_back(ev_t'{op: OP_LDA, a: 1'b1, b: 1'b0, val: abase + ainc * 32'(i)});
    for (int i = 0; i < N; i++) exp_ev.push_back(ev_t'{op: OP_LDB, a: 1'b0, b: 1'b1, val: bbase + binc * 32'(i)});
    exp_ev.push_back(ev_t'{op: OP_MUL, a: 1'b0, b: 1'b0, val: 32'd0});
    if (reads) begin
      for (int i = 0; i < N; i++) begin
        exp_ev.push_back(ev_t'{op: OP_READ, a: 1'b0, b: 1'b0, val: 32'd0});
        exp_out.push_back({i == N - 1, rbase + 32'(i)});
      end
    end
    res_base = rbase;
    rd_idx = 0;
    first_lda = -1;
    first_rd_cyc = -1;
  endtask

  task automatic issue_cmd(input logic [31:0] addr);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic stream(input logic [31:0] abase, input logic [31:0] ainc, input logic [31:0] bbase,
                        input logic [31:0] binc, input bit toggle, input int stop);
    int i = 0;
    int t = 0;
    while (i < stop && t < 2000) begin
      @(negedge clk);
      t++;
      if (toggle && (t % 2 == 0)) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = (i < N) ? abase + ainc * 32'(i) : bbase + binc * 32'(i - N);
        if (in_ready) i++;
      end
    end
    if (i < stop) chk("stream_timeout", 64'(i), 64'(stop));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] addr, input logic [31:0] abase, input logic [31:0] ainc,
                         input logic [31:0] bbase, input logic [31:0] binc, input bit toggle,
                         input logic [31:0] rbase, input bit stall);
    int d0 = done_cnt;
    int t = 0;
    int stall_reads = 0;
    push_job(addr, abase, ainc, bbase, binc, rbase, 1);
    issue_cmd(addr);
    stream(abase, ainc, bbase, binc, toggle, 2 * N);
    if (stall) begin
      while (first_rd_cyc < 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      out_ready = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (ME_opcode == OP_READ) stall_reads++;
      end
      chk("stall_reads_le2", 64'(stall_reads <= 2), 64'd1);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
    end
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("events_drained", 64'(exp_ev.size()), 64'd0);
    chk("outputs_drained", 64'(exp_out.size()), 64'd0);
    chk("lda_span", 64'(last_lda - first_lda), toggle ? 64'd30 : 64'd15);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_rst("rst_init");
    reset = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);

    run_job(32'h0000_1000, 32'hA5A5A5A5, 32'd0, 32'h5A5A5A5A, 32'd0, 1'b0, 32'hC0DE_0000, 1'b0);
    run_job(32'h0000_2000, 32'h1111_0000, 32'd1, 32'h2222_0000, 32'd3, 1'b1, 32'hBEEF_0100, 1'b0);

    busy_len = 50;
    fall_cyc = -1;
    run_job(32'h0000_2400, 32'h0A00_0000, 32'd5, 32'h0B00_0000, 32'd7, 1'b0, 32'h3300_0000, 1'b0);
    chk("rd_after_busy_fall", 64'((fall_cyc >= 0) && (first_rd_cyc - fall_cyc >= 1) && (first_rd_cyc - fall_cyc <= 2)), 64'd1);
    busy_len = 0;

    run_job(32'h0000_2800, 32'h4400_0000, 32'd1, 32'h5500_0000, 32'd1, 1'b0, 32'h7700_0000, 1'b1);

    push_job(32'h0000_2C00, 32'h6600_0000, 32'd1, 32'h6700_0000, 32'd1, 32'h8800_0000, 1);
    issue_cmd(32'h0000_2C00);
    stream(32'h6600_0000, 32'd1, 32'h6700_0000, 32'd1, 1'b0, N + 8);
    reset = 1'b0;
    exp_ev.delete();
    exp_out.delete();
    #1;
    chk_rst("rst_abort");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job(32'h0000_3000, 32'h0C00_0000, 32'd2, 32'h0D00_0000, 32'd2, 1'b0, 32'h9900_0000, 1'b0);

`ifdef ME_SEQ_TIMEOUT_EN
    begin
      int d0;
      int t;
      d0 = done_cnt;
      t = 0;
      push_job(32'h0000_3400, 32'h0E00_0000, 32'd1, 32'h0F00_0000, 32'd1, 32'h0, 0);
      busy_stuck = 1;
      issue_cmd(32'h0000_3400);
      stream(32'h0E00_0000, 32'd1, 32'h0F00_0000, 32'd1, 1'b0, 2 * N);
      while (ME_opcode != OP_MUL && t < 200) begin
        @(negedge clk);
        t++;
      end
      repeat (31) @(negedge clk);
      chk("tmo_wait32", 64'(timeout_err), 64'd0);
      @(negedge clk);
      chk("tmo_wait33", 64'(timeout_err), 64'd1);
      chk("tmo_cmd_ready", 64'(cmd_ready), 64'd1);
      busy_stuck = 0;
      repeat (5) @(negedge clk);
      chk("tmo_no_done", 64'(done_cnt - d0), 64'd0);
      chk("tmo_sticky", 64'(timeout_err), 64'd1);
      run_job(32'h0000_3800, 32'h1200_0000, 32'd1, 32'h1300_0000, 32'd1, 1'b0, 32'h4400_0000, 1'b0);
      chk("tmo_cleared", 64'(timeout_err), 64'd0);
    end
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/me_job_sequencer.md
Name: me_job_sequencer

Overview:
- Controller that runs one complete matrix-multiply job on the LilME engine: load address, stream N=row*col words into matrix A, then N into B, issue MUL, wait for completion, read back N result words.
- Sits between a host/DMA stream interface and the LilME ports; it is the only driver of ME_opcode, A_opcode, B_opcode, Address_out and Data_in.
- Result words leave through a back-pressured stream backed by a 2-entry buffer.

Parameters:
- dw, 31, MSB index of data words (width dw+1)
- aw, 31, MSB index of address (width aw+1)
- row, 4, matrix rows
- col, 4, matrix columns; N = row*col words per matrix
- RD_LAT, 1, cycles from a READ opcode (111) to a valid word on result

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset (0 = reset)
- cmd_valid  input  1  job request
- cmd_ready  output  1  high only in IDLE
- cmd_addr  input  aw+1  job base address
- in_valid  input  1  operand word valid
- in_ready  output  1  operand word accepted when in_valid & in_ready
- in_data  input  dw+1  operand word; first N go to A, next N to B
- out_valid  output  1  result word valid
- out_ready  input  1  consumer ready
- out_data  output  dw+1  result word
- out_last  output  1  marks Nth result word
- done  output  1  one-cycle pulse when the last result word is accepted
- ME_opcode  output  3  engine opcode: 000 IDLE, 001 LOAD_ADDR, 010 LOAD_A, 011 LOAD_B, 101 MUL, 111 READ
- A_opcode  output  1  A-load strobe
- B_opcode  output  1  B-load strobe
- Address_out  output  aw+1  engine address
- Data_in  output  dw+1  engine data word
- Busy  input  1  engine busy
- result  input  dw+1  engine result word

Behaviour:
- Reset values: ME_opcode=000, A_opcode=B_opcode=0, Address_out=0, Data_in=0, cmd_ready=0 while reset is asserted and 1 in IDLE after release; in_ready=out_valid=out_last=done=0; out_data=0; counters 0; FIFO empty.
- All engine outputs are registered. ME_opcode returns to 000 in any cycle with no action.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr and go to ADDR.
- ADDR: one cycle with ME_opcode=001 and Address_out=latched address, then LOAD_A.
- LOAD_A: in_ready=1. Each accepted beat drives ME_opcode=010, A_opcode=1, Data_in=in_data on the next cycle. Gaps (in_valid=0) drive 000/0. After beat N-1, go to LOAD_B.
- LOAD_B: same as LOAD_A with 011 and B_opcode=1.
- MUL: one cycle with 101, then WAIT. WAIT ignores Busy in its first cycle and exits when Busy=0 is sampled on any later cycle. This tolerates one cycle of Busy-assert delay.
- READ: issue 111 only when fifo_count + inflight < 2, where inflight counts reads issued but not yet captured. Capture result RD_LAT cycles after each 111 into the FIFO. After N reads issued, stop issuing. Go to IDLE when the Nth word is accepted, with done pulsing in that cycle.
- Output: out_valid = FIFO non-empty. The word at the FIFO head is held stable until accepted. out_last is asserted on read index N-1.
- Counters are clog2(N+1) wide and wrap to 0 at each state entry.
- cmd_valid is ignored outside IDLE. in_ready=0 outside the LOAD states.
- Asserting reset mid-job aborts at once: the job is discarded, no done pulse, FIFO flushed, engine outputs forced to 000/0.

Optional Feature:
- ME_SEQ_TIMEOUT_EN: adds parameter TMO (default 1024) and output port timeout_err.
  - If WAIT exceeds TMO cycles, go to IDLE without reading, assert timeout_err sticky, and suppress done. timeout_err clears on the next accepted command.
- Without the macro: WAIT is unbounded and the timeout_err port is absent.

Decomposition:
- Package me_seq_pkg: opcode localparams (OP_IDLE=3'b000, OP_LDADDR=3'b001, OP_LDA=3'b010, OP_LDB=3'b011, OP_MUL=3'b101, OP_READ=3'b111) and state encoding (IDLE, ADDR, LOAD_A, LOAD_B, MUL, WAIT, READ).
- Sub-module me_seq_outbuf: 2-entry FIFO carrying {last, data} with count output.

Test Plan:
- Full job, cmd_addr=0x00001000, A=0xA5A5A5A5 x16, B=0x5A5A5A5A x16, in_valid always 1 -> exactly one 001 with Address_out=0x1000, 16 cycles of 010/A_opcode=1, 16 of 011/B_opcode=1, one 101, 16 words out, out_last on the 16th, done pulses once.
- in_valid toggling 1/0 during LOAD_A -> 16 A strobes interleaved with 000 cycles; Data_in matches beat order 0..15.
- Busy held high 50 cycles after MUL -> no 111 issued until the cycle after Busy falls.
- out_ready=0 for 20 cycles during READ -> at most 2 reads issued, out_data stable, no words lost; 16 words delivered in order.
- reset pulled low during LOAD_B beat 7 -> all outputs at reset values; a new job afterwards completes normally.
- With ME_SEQ_TIMEOUT_EN, TMO=32, Busy stuck high -> timeout_err=1 at WAIT cycle 33, cmd_ready=1, done never pulses.
